// File: rtl/rs232_transmitter.sv
// rs232_transmitter: stream-to-UART 8N1 transmitter; define RS232_TRANSMITTER_PARITY_EN for an even-parity bit (8E1).
module rs232_transmitter #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rs232_tx,
  input  logic        rs232_tx_stb,
  output logic        rs232_tx_ack,
  output logic        tx
);
  localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW = CLOCKS_PER_BIT > 1 ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);
`ifdef RS232_TRANSMITTER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] data;
  logic bit_end;
  logic xfer;
  logic unused_hi;
  assign bit_end = cnt == LAST;
  assign xfer = rs232_tx_ack && rs232_tx_stb;
  assign unused_hi = ^rs232_tx[31:8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      rs232_tx_ack <= 1'b0;
      cnt <= '0;
      idx <= '0;
      data <= '0;
    end else begin
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          tx <= !xfer;
          rs232_tx_ack <= !xfer;
          if (xfer) begin
            data <= rs232_tx[7:0];
            state <= START;
          end
        end
        START: if (bit_end) begin
          state <= DATA;
          tx <= data[0];
        end
        DATA: if (bit_end) begin
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef RS232_TRANSMITTER_PARITY_EN
            state <= PARITY;
            tx <= ^data;
`else
            state <= STOP;
            tx <= 1'b1;
`endif
          end else
            tx <= data[idx + 3'd1];
        end
`ifdef RS232_TRANSMITTER_PARITY_EN
        PARITY: if (bit_end) begin
          state <= STOP;
          tx <= 1'b1;
        end
`endif
        STOP: if (bit_end) begin
          state <= IDLE;
          rs232_tx_ack <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rs232_transmitter.sv
// tb_rs232_transmitter: directed checks of framing, handshake, reset and mid-frame isolation at 10 clocks per bit.
module tb_rs232_transmitter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] rs232_tx = '0;
  logic rs232_tx_stb = 1'b0;
  logic rs232_tx_ack;
  logic tx;
  int total = 0;
  int bad = 0;
  int xfers = 0;
`ifdef RS232_TRANSMITTER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  rs232_transmitter #(.CLOCK_FREQUENCY(1000), .BAUD_RATE(100)) dut (
    .clk(clk), .rst(rst), .rs232_tx(rs232_tx), .rs232_tx_stb(rs232_tx_stb),
    .rs232_tx_ack(rs232_tx_ack), .tx(tx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (!rst && rs232_tx_ack && rs232_tx_stb) xfers <= xfers + 1;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && NB == 11) return ^d;
    return 1'b1;
  endfunction
  // Entered one cycle after the transfer edge; leaves in the idle cycle after STOP.
  task automatic check_frame(input string tag, input logic [7:0] d);
    int errs = 0;
    for (int k = 0; k < NB; k++)
      for (int c = 0; c < 10; c++) begin
        if (tx !== frame_bit(d, k) || rs232_tx_ack !== 1'b0) begin
          errs++;
          $display("FAIL %s bit %0d cycle %0d tx=%b want=%b ack=%b", tag, k, c, tx, frame_bit(d, k), rs232_tx_ack);
        end
        tick();
      end
    chk({tag, "_frame_errs"}, errs, 0);
    chk({tag, "_ack_after"}, rs232_tx_ack, 1'b1);
    chk({tag, "_idle_tx"}, tx, 1'b1);
  endtask
  task automatic send(input string tag, input logic [31:0] w);
    rs232_tx = w;
    rs232_tx_stb = 1'b1;
    tick();
    rs232_tx_stb = 1'b0;
    chk({tag, "_ack_drop"}, rs232_tx_ack, 1'b0);
    chk({tag, "_start_latency"}, tx, 1'b0);
    check_frame(tag, w[7:0]);
  endtask
  initial begin
    int x0;
    tick(2);
    chk("rst_tx", tx, 1'b1);
    chk("rst_ack", rs232_tx_ack, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_ack", rs232_tx_ack, 1'b1);
    rs232_tx = 32'hDEADBEEF;
    tick(5);
    chk("idle_no_stb_tx", tx, 1'b1);
    chk("idle_no_stb_xfers", xfers, 0);
    send("w55", 32'h0000_0055);
    send("w41", 32'hFFFF_FF41);
    x0 = xfers;
    rs232_tx = 32'h01;
    rs232_tx_stb = 1'b1;
    tick();
    rs232_tx = 32'h02;
    check_frame("b2b1", 8'h01);
    tick();
    rs232_tx = 32'h03;
    check_frame("b2b2", 8'h02);
    tick();
    rs232_tx_stb = 1'b0;
    check_frame("b2b3", 8'h03);
    tick(3);
    chk("b2b_xfers", xfers - x0, 3);
    rs232_tx = 32'hAA;
    rs232_tx_stb = 1'b1;
    tick();
    rs232_tx_stb = 1'b0;
    tick(45);
    rst = 1'b1;
    tick();
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_ack", rs232_tx_ack, 1'b0);
    rst = 1'b0;
    tick();
    chk("midrst_ack_back", rs232_tx_ack, 1'b1);
    x0 = xfers;
    rst = 1'b1;
    rs232_tx = 32'h80;
    rs232_tx_stb = 1'b1;
    tick();
    rs232_tx_stb = 1'b0;
    chk("rst_prio_ack", rs232_tx_ack, 1'b0);
    chk("rst_prio_tx", tx, 1'b1);
    rst = 1'b0;
    tick(3);
    chk("rst_prio_xfers", xfers - x0, 0);
    chk("rst_prio_idle_tx", tx, 1'b1);
    send("w80", 32'h80);
    rs232_tx = 32'h0F;
    rs232_tx_stb = 1'b1;
    tick();
    rs232_tx_stb = 1'b0;
    rs232_tx = 32'hF0;
    check_frame("w0f", 8'h0F);
`ifdef RS232_TRANSMITTER_PARITY_EN
    send("par07", 32'h07);
    send("par03", 32'h03);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rs232_transmitter.md
RS232_TRANSMITTER -- requirements
Module: rs232_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning serial bit rate in bits/s.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rs232_tx, input, 32 bits: stream data word; bits [7:0] transmitted, [31:8] ignored.
REQ-006 SHALL have port rs232_tx_stb, input, 1 bit: producer strobe, word valid.
REQ-007 SHALL have port rs232_tx_ack, output, 1 bit: acknowledge, word consumed.
REQ-008 SHALL have port tx, output, 1 bit: UART serial line, idle high.

Function
REQ-009 SHALL derive CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE (integer division, truncating); each serial bit held exactly CLOCKS_PER_BIT cycles.
REQ-010 SHALL implement states IDLE, START, DATA, PARITY (REQ-022 only), STOP.
REQ-011 SHALL assert rs232_tx_ack (registered) only in IDLE; transfer occurs on an edge where rs232_tx_stb and rs232_tx_ack are both high.
REQ-012 SHALL latch rs232_tx[7:0] on the transfer edge and drive rs232_tx_ack low the following cycle; one transfer per frame, never two consecutive ack-high transfer edges.
REQ-013 SHALL drive tx low (start bit) from the cycle after the transfer edge: latency 1 clock.
REQ-014 SHALL send DATA as 8 bits, LSB first, then STOP as one bit of tx=1.
REQ-015 SHALL return to IDLE after the STOP bit completes, ack re-asserting on the next cycle; back-to-back frames spaced by at most 1 idle cycle plus frame time.
REQ-016 SHALL keep tx high and ignore rs232_tx contents while rs232_tx_stb is low in IDLE.
REQ-017 SHALL not sample rs232_tx or rs232_tx_stb outside the transfer edge; changes mid-frame have no effect.
REQ-018 SHALL wrap the bit-timing counter to 0 at CLOCKS_PER_BIT-1 and the bit index to 0 after bit 7.

Reset
REQ-019 SHALL, on rst high at a clock edge, set state IDLE, tx=1, rs232_tx_ack=0, counters=0.
REQ-020 SHALL abandon any frame in progress on reset (tx=1 next cycle), with no ack until rst is low for one cycle.
REQ-021 SHALL take rst priority over a simultaneous transfer edge: word not accepted.

Configuration
REQ-022 SHALL, when macro RS232_TRANSMITTER_PARITY_EN is defined, insert a PARITY bit between bit 7 and STOP equal to XOR of data[7:0] (even parity), frame 11 bits.
REQ-023 SHALL, without RS232_TRANSMITTER_PARITY_EN, omit PARITY state and logic entirely, frame 10 bits.

Verification (CLOCK_FREQUENCY=1000, BAUD_RATE=100, CLOCKS_PER_BIT=10)
REQ-024 SHALL cover: stb high with rs232_tx=0x00000055 -> ack 1 cycle, tx low 10 cycles, then 1,0,1,0,1,0,1,0 each 10 cycles, high 10 cycles; 100-cycle frame.
REQ-025 SHALL cover: rs232_tx=0xFFFFFF41 -> serial data 0x41 only (1,0,0,0,0,0,1,0), upper bits ignored.
REQ-026 SHALL cover: stb held high for 3 words 0x01,0x02,0x03 -> exactly 3 acks, 3 frames, each ack 1 cycle after prior STOP ends.
REQ-027 SHALL cover: rst asserted at cycle 45 of a frame -> tx=1 next cycle, ack low, new word 0x80 after release transmits cleanly.
REQ-028 SHALL cover: with RS232_TRANSMITTER_PARITY_EN, 0x07 -> parity bit 1 (10 cycles) before stop, 110-cycle frame; 0x03 -> parity bit 0.
REQ-029 SHALL cover: rs232_tx changed from 0x0F to 0xF0 mid-frame with stb low -> frame still carries 0x0F.
